// File: rtl/sequenciador_polinomio.sv
// sequenciador_polinomio: Moore controller that steps the operative block
// (three muxes, shared ULA, Reg_X/Reg_H/Reg_S) through Horner's method.
// Mode 0 evaluates a*x^2 + b*x + c; mode 1 evaluates a*x + b.
// Every control output is registered and encodes the state being entered,
// so the outputs always match the current state with no decode glitches.
module sequenciador_polinomio #(
  parameter logic OP_ADD = 1'b0,
  parameter logic OP_MUL = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       mode,
  output logic       h,
  output logic       LS,
  output logic       LX,
  output logic       LH,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CTL_W = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADX = 3'd1,
    S_MUL1  = 3'd2,
    S_ADDB  = 3'd3,
    S_MUL2  = 3'd4,
    S_FINC  = 3'd5,
    S_FINB  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t state;
  logic   mode_q;

  // Transition function; mode_q selects the quadratic or linear tail after MUL1.
  function automatic state_t next_state(input state_t s, input logic st, input logic mq);
    state_t n;
    n = S_IDLE;
    case (s)
      S_IDLE:  n = st ? S_LOADX : S_IDLE;
      S_LOADX: n = S_MUL1;
      S_MUL1:  n = mq ? S_FINB : S_ADDB;
      S_ADDB:  n = S_MUL2;
      S_MUL2:  n = S_FINC;
      S_FINC:  n = S_DONE;
      S_FINB:  n = S_DONE;
      S_DONE:  n = S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  // Control word for a state: {h, LS, LX, LH, m0, m1, m2, busy, done}.
  function automatic logic [CTL_W-1:0] decode(input state_t s);
    logic       hh, ls, lx, lh, bz, dn;
    logic [1:0] s0, s1, s2;
    hh = OP_ADD;
    ls = 1'b0;
    lx = 1'b0;
    lh = 1'b0;
    s0 = 2'b00;
    s1 = 2'b00;
    s2 = 2'b00;
    bz = 1'b1;
    dn = 1'b0;
    case (s)
      S_IDLE: begin
        hh = 1'b0;
        bz = 1'b0;
      end
      S_LOADX: lx = 1'b1;
      // H <= a * X
      S_MUL1: begin
        s0 = 2'b00; s2 = 2'b01; s1 = 2'b01; hh = OP_MUL; lh = 1'b1;
      end
      // H <= H + b
      S_ADDB: begin
        s0 = 2'b10; s2 = 2'b11; s1 = 2'b00; hh = OP_ADD; lh = 1'b1;
      end
      // H <= H * X
      S_MUL2: begin
        s2 = 2'b11; s1 = 2'b01; hh = OP_MUL; lh = 1'b1;
      end
      // S <= H + c
      S_FINC: begin
        s0 = 2'b11; s2 = 2'b11; s1 = 2'b00; hh = OP_ADD; ls = 1'b1;
      end
      // S <= H + b
      S_FINB: begin
        s0 = 2'b10; s2 = 2'b11; s1 = 2'b00; hh = OP_ADD; ls = 1'b1;
      end
      S_DONE: dn = 1'b1;
      default: begin
        hh = 1'b0;
        bz = 1'b0;
      end
    endcase
    return {hh, ls, lx, lh, s0, s1, s2, bz, dn};
  endfunction

  // State, captured mode and registered control outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      {h, LS, LX, LH, m0, m1, m2, busy, done} <= CTL_W'(0);
    end else begin
      state <= next_state(state, start, mode_q);
      if (state == S_IDLE && start) begin
        mode_q <= mode;
      end
      {h, LS, LX, LH, m0, m1, m2, busy, done} <= decode(next_state(state, start, mode_q));
    end
  end

endmodule
